// File: rtl/btpipe_block_source.sv
// Transmit end of a block-throttled pipe: waits for receiver credit, marks each
// block with a strobe, then bursts PRBS or counter words with no bubbles.
module btpipe_block_source #(
    parameter int          BLK_W = 10,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [BLK_W-1:0] block_len,
    input  logic [15:0]      block_count,
    input  logic             ep_ready,
    output logic             ep_blockstrobe,
    output logic             ep_write,
    output logic [15:0]      ep_dataout,
    output logic             busy,
    output logic             done,
    output logic [15:0]      blocks_sent
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_STROBE, S_BURST, S_GAP} state_t;

    state_t             state_q, state_d;
    logic               stop_pend_q, stop_pend_d;
    logic               done_q, done_d;
    logic [15:0]        bs_q, bs_d;
    logic [BLK_W-1:0]   beat_q, beat_d;
    logic               mode_q, mode_d;
    logic [BLK_W-1:0]   len_q, len_d;
    logic [15:0]        bcnt_q, bcnt_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [15:0]        ctr_q, ctr_d;
    logic [15:0]        dout_q, dout_d;
    logic               emit;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        bs_d        = bs_q;
        beat_d      = beat_q;
        mode_d      = mode_q;
        len_d       = len_q;
        bcnt_d      = bcnt_q;
        lfsr_d      = lfsr_q;
        ctr_d       = ctr_q;
        dout_d      = dout_q;
        emit        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    len_d       = block_len;
                    bcnt_d      = block_count;
                    lfsr_d      = SEED;
                    ctr_d       = 16'h0001;
                    bs_d        = '0;
                    stop_pend_d = 1'b0;
                    state_d     = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (ep_ready) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (stop) stop_pend_d = 1'b1;
                beat_d  = '0;
                emit    = 1'b1;
                state_d = S_BURST;
            end
            S_BURST: begin
                if (stop) stop_pend_d = 1'b1;
                if (beat_q == len_q) begin
                    state_d = S_GAP;
                end else begin
                    beat_d = beat_q + 1'b1;
                    emit   = 1'b1;
                end
            end
            S_GAP: begin
                bs_d = bs_q + 16'd1;
                // Saturate the session at 16'hFFFF rather than let the count wrap.
                if (stop_pend_q || stop || (bcnt_q != 16'd0 && bs_d == bcnt_q) ||
                    bs_d == 16'hFFFF) begin
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_RDY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load the word for the upcoming write cycle so it is valid with ep_write.
        if (emit) begin
            dout_d = mode_q ? ctr_q : lfsr_q[15:0];
            ctr_d  = ctr_q + 16'd1;
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            bs_q        <= '0;
            beat_q      <= '0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            bcnt_q      <= '0;
            lfsr_q      <= SEED;
            ctr_q       <= 16'h0001;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            bs_q        <= bs_d;
            beat_q      <= beat_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            bcnt_q      <= bcnt_d;
            lfsr_q      <= lfsr_d;
            ctr_q       <= ctr_d;
            dout_q      <= dout_d;
        end
    end

    assign ep_blockstrobe = (state_q == S_STROBE);
    assign ep_write       = (state_q == S_BURST);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign ep_dataout     = dout_q;
    assign blocks_sent    = bs_q;

endmodule

// File: tb/tb_btpipe_block_source.sv
// Directed bench for btpipe_block_source: hand-computed words, strobes and session ends.
module tb_btpipe_block_source;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  block_len = '0;
    logic [15:0] block_count = '0;
    logic        ep_ready = 1'b0;
    logic        ep_blockstrobe, ep_write, busy, done;
    logic [15:0] ep_dataout, blocks_sent;

    int n_tests = 0;
    int n_fail  = 0;

    btpipe_block_source #(.BLK_W(10), .SEED(32'h0000_0001)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .block_len(block_len), .block_count(block_count), .ep_ready(ep_ready),
        .ep_blockstrobe(ep_blockstrobe), .ep_write(ep_write), .ep_dataout(ep_dataout),
        .busy(busy), .done(done), .blocks_sent(blocks_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_write", ep_write, 1'b0);
        chk1("rst_strobe", ep_blockstrobe, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk16("rst_dout", ep_dataout, 16'h0000);
        chk16("rst_bs", blocks_sent, 16'h0000);

        // Counter mode, 2 blocks of 4 words
        mode = 1'b1; block_len = 10'd3; block_count = 16'd2; ep_ready = 1'b1;
        pulse_start();
        chk1("c_wait_busy", busy, 1'b1);
        chk1("c_wait_strobe", ep_blockstrobe, 1'b0);
        for (int b = 0; b < 2; b++) begin
            tick();
            chk1("c_strobe", ep_blockstrobe, 1'b1);
            chk1("c_strobe_nowrite", ep_write, 1'b0);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk1("c_write", ep_write, 1'b1);
                chk1("c_write_nostrobe", ep_blockstrobe, 1'b0);
                chk16("c_data", ep_dataout, 16'(b * 4 + i + 1));
            end
            tick();
            chk1("c_gap_write", ep_write, 1'b0);
            chk16("c_gap_hold", ep_dataout, 16'(b * 4 + 4));
            chk16("c_gap_bs", blocks_sent, 16'(b));
            if (b == 0) begin
                tick();
                chk16("c_wait_bs", blocks_sent, 16'd1);
            end
        end
        tick();
        chk1("c_done", done, 1'b1);
        chk1("c_end_busy", busy, 1'b0);
        chk16("c_end_bs", blocks_sent, 16'd2);
        tick();
        chk1("c_done_once", done, 1'b0);

        // PRBS mode, seed 1: 0001, 0003, 0006, 000D
        mode = 1'b0; block_len = 10'd3; block_count = 16'd1;
        pulse_start();
        tick();
        chk1("p_strobe", ep_blockstrobe, 1'b1);
        tick(); chk16("p_w0", ep_dataout, 16'h0001);
        tick(); chk16("p_w1", ep_dataout, 16'h0003);
        tick(); chk16("p_w2", ep_dataout, 16'h0006);
        tick(); chk16("p_w3", ep_dataout, 16'h000D);
        tick(); tick();
        chk1("p_done", done, 1'b1);
        chk16("p_bs", blocks_sent, 16'd1);

        // Held-off ready: no strobe/write for 10 cycles, strobe right after rise
        mode = 1'b1; block_len = 10'd1; block_count = 16'd1; ep_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk1("r_no_strobe", ep_blockstrobe, 1'b0);
            chk1("r_no_write", ep_write, 1'b0);
            chk1("r_busy", busy, 1'b1);
            if (i < 9) tick();
        end
        ep_ready = 1'b1;
        tick();
        chk1("r_strobe", ep_blockstrobe, 1'b1);
        tick(); chk16("r_w0", ep_dataout, 16'h0001);
        tick(); chk16("r_w1", ep_dataout, 16'h0002);
        tick(); tick();
        chk1("r_done", done, 1'b1);

        // Stop on 2nd burst cycle: block completes, then done with 1 block
        block_len = 10'd3; block_count = 16'd0;
        pulse_start();
        tick(); tick();
        chk16("s_w0", ep_dataout, 16'h0001);
        tick();
        chk16("s_w1", ep_dataout, 16'h0002);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk1("s_w2_write", ep_write, 1'b1);
        chk16("s_w2", ep_dataout, 16'h0003);
        tick();
        chk16("s_w3", ep_dataout, 16'h0004);
        tick();
        chk1("s_gap_write", ep_write, 1'b0);
        tick();
        chk1("s_done", done, 1'b1);
        chk1("s_idle", busy, 1'b0);
        chk16("s_bs", blocks_sent, 16'd1);

        // Stop while waiting for ready: immediate done, no block
        ep_ready = 1'b0;
        pulse_start();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk1("sw_idle", busy, 1'b0);
        chk1("sw_done", done, 1'b1);
        chk16("sw_bs", blocks_sent, 16'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk1("si_ignored", done, 1'b0);
        chk1("si_idle", busy, 1'b0);

        // Reset on 3rd burst cycle; start/config change mid-burst ignored
        ep_ready = 1'b1; block_len = 10'd7;
        pulse_start();
        tick(); tick(); tick();
        start = 1'b1; mode = 1'b0; block_len = 10'd0;
        tick();
        start = 1'b0; mode = 1'b1;
        chk1("x_write", ep_write, 1'b1);
        chk16("x_ignore_start", ep_dataout, 16'h0003);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("x_write_off", ep_write, 1'b0);
        chk1("x_busy_off", busy, 1'b0);
        chk16("x_dout_clr", ep_dataout, 16'h0000);
        block_len = 10'd1; block_count = 16'd1;
        pulse_start();
        tick(); tick();
        chk16("x_restart", ep_dataout, 16'h0001);
        tick(); tick(); tick();
        chk1("x_done", done, 1'b1);

        // Single-word blocks, three of them
        block_len = 10'd0; block_count = 16'd3;
        pulse_start();
        for (int b = 0; b < 3; b++) begin
            tick();
            chk1("z_strobe", ep_blockstrobe, 1'b1);
            tick();
            chk1("z_write", ep_write, 1'b1);
            chk16("z_data", ep_dataout, 16'(b + 1));
            tick();
            chk1("z_gap", ep_write | ep_blockstrobe, 1'b0);
            if (b < 2) tick();
        end
        tick();
        chk1("z_done", done, 1'b1);
        chk16("z_bs", blocks_sent, 16'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btpipe_block_source.md
BTPIPE_BLOCK_SOURCE -- requirements
Module: btpipe_block_source

Interface
REQ-001 Parameters (name, default, meaning):
- BLK_W, 10, width of block length field.
- SEED, 32'h0000_0001, LFSR seed (nonzero).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, reset input.
- start, in, 1, one-cycle pulse that begins a transfer session.
- stop, in, 1, one-cycle pulse that ends the session after the current block.
- mode, in, 1, data pattern select: 0 = PRBS, 1 = counter.
- block_len, in, BLK_W, words per block minus 1.
- block_count, in, 16, number of blocks to send; 0 = unlimited.
- ep_ready, in, 1, receiver can accept one full block.
- ep_blockstrobe, out, 1, one-cycle marker immediately preceding each block.
- ep_write, out, 1, data-valid strobe.
- ep_dataout, out, 16, data word.
- busy, out, 1, session active.
- done, out, 1, one-cycle pulse at session end.
- blocks_sent, out, 16, completed blocks in the current session.
REQ-003 The block has one clock; reset is synchronous and active-high.

Function
REQ-004 The block is the transmitting end of a block-throttled pipe: it generates the traffic that pipe_in_check consumes, with no host involvement.
REQ-005 FSM states are IDLE, WAIT_RDY, STROBE, BURST and GAP.
REQ-006 start in IDLE:
- latches mode, block_len and block_count;
- reloads the generator;
- clears blocks_sent;
- moves to WAIT_RDY.
REQ-007 start outside IDLE is ignored.
REQ-008 WAIT_RDY moves to STROBE on the first cycle ep_ready=1; otherwise it holds.
REQ-009 STROBE lasts exactly one cycle with ep_blockstrobe=1 and ep_write=0, then moves to BURST.
REQ-010 BURST asserts ep_write on exactly block_len+1 consecutive cycles, with no bubbles.
- ep_ready is not sampled during BURST.
- After the last word, the FSM moves to GAP.
REQ-011 GAP lasts exactly one cycle and increments blocks_sent. From GAP:
- go to IDLE, pulsing done there, if any of these hold: stop is pending; block_count≠0 and the new blocks_sent equals block_count; blocks_sent would wrap.
- otherwise go to WAIT_RDY.
REQ-012 stop handling:
- stop in WAIT_RDY moves to IDLE next cycle with a done pulse and no partial block.
- stop in STROBE or BURST sets a pending flag; the block completes.
- stop in IDLE is ignored.
REQ-013 busy=1 in every state except IDLE.
REQ-014 Generator, mode 0 (PRBS):
- 32-bit Fibonacci LFSR, taps 32,22,2,1, shifting left.
- New LSB = b31^b21^b1^b0.
- ep_dataout = lfsr[15:0].
- The LFSR advances once per ep_write cycle.
REQ-015 Generator, mode 1 (counter): the first word is 16'h0001, incrementing by 1 per written word and wrapping 16'hFFFF→16'h0000.
REQ-016 The generator state persists across blocks within a session; it reloads only on start or reset.
REQ-017 ep_dataout is registered and valid in the same cycle as ep_write. It holds its last value when ep_write=0.
REQ-018 ep_blockstrobe and ep_write are never asserted in the same cycle.
REQ-019 block_len=0 gives single-word blocks: STROBE, one BURST cycle, GAP.
REQ-020 Changing mode, block_len or block_count while busy has no effect until the next start.

Reset
REQ-021 reset has priority over all other inputs. It forces:
- state IDLE;
- ep_write=0, ep_blockstrobe=0, busy=0, done=0;
- ep_dataout=0, blocks_sent=0;
- LFSR=SEED, counter=16'h0001;
- stop pending cleared.
REQ-022 reset mid-BURST aborts the block immediately; ep_write is 0 on the next cycle.

Verification
REQ-023 Counter mode, block_len=3, block_count=2, ep_ready=1. start → per block, STROBE then 4 writes. Data 0001..0004, then 0005..0008. blocks_sent=2, then done pulses once.
REQ-024 PRBS mode, SEED=1. The first three words equal the LFSR[15:0] values after 0, 1 and 2 shifts, as checked against a reference model.
REQ-025 ep_ready held 0 for 10 cycles after start → no strobe or write for those cycles. The first strobe occurs the cycle after ep_ready rises.
REQ-026 stop on the 2nd BURST cycle of block 1 (block_count=0) → block 1 completes all words. Then IDLE, done=1, blocks_sent=1.
REQ-027 reset on the 3rd BURST cycle → next cycle ep_write=0, busy=0. A following start restarts the data from 0001 (counter mode).
REQ-028 block_len=0, block_count=3 → three strobe/write pairs separated by GAP. blocks_sent=3.
